// File: rtl/exe.sv
// Single-cycle 8-bit ALU: combinational result, registered output and N/Z flags.
// Opcode F is a NOP that freezes all registered state.
module exe (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Ira,
    input  logic [7:0] Irb,
    input  logic [3:0] OPALU,
    input  logic       NFCR,
    input  logic       ZFCR,
    output logic [7:0] OALUD,
    output logic       IFgn,
    output logic       IFgz
);

    typedef struct packed {
        logic [7:0] res;
        logic       neg;
        logic       zero;
        logic       nop;
    } alu_rsp_t;

    alu_rsp_t rsp;

    always_comb begin
        rsp = '0;
        unique case (OPALU)
            4'h0: rsp.res = Ira;
            4'h1: rsp.res = Ira + Irb;
            4'h2: rsp.res = Ira - Irb;
            4'h3: rsp.res = Ira & Irb;
            4'h4: rsp.res = Ira | Irb;
            4'h5: rsp.res = Ira ^ Irb;
            4'h6: rsp.res = ~Ira;
            4'h7: rsp.res = {Ira[6:0], 1'b0};
            4'h8: rsp.res = {1'b0, Ira[7:1]};
            4'h9: rsp.res = {Ira[7], Ira[7:1]};
            4'hA: rsp.res = {Ira[6:0], Ira[7]};
            4'hB: rsp.res = {Ira[0], Ira[7:1]};
            4'hC: rsp.res = Ira + 8'd1;
            4'hD: rsp.res = Ira - 8'd1;
            4'hE: rsp.res = Irb;
            default: rsp.nop = 1'b1;
        endcase
        // Flags come from the truncated result; any carry is already gone.
        rsp.neg  = rsp.res[7];
        rsp.zero = (rsp.res == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            OALUD <= 8'h00;
            IFgn  <= 1'b0;
            IFgz  <= 1'b0;
        end else if (!rsp.nop) begin
            OALUD <= rsp.res;
            if (NFCR) IFgn <= rsp.neg;
            if (ZFCR) IFgz <= rsp.zero;
        end
    end

endmodule

// File: tb/tb_exe.sv
// Scoreboard bench for exe: expectations queued at drive time, compared after each edge.
module tb_exe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Ira, Irb;
    logic [3:0] OPALU;
    logic       NFCR, ZFCR;
    logic [7:0] OALUD;
    logic       IFgn, IFgz;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       n;
        logic       z;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    // reference state tracked by the bench
    logic [7:0] m_d = 8'h00;
    logic       m_n = 1'b0;
    logic       m_z = 1'b0;

    exe dut (
        .clk(clk), .rst(rst), .Ira(Ira), .Irb(Irb), .OPALU(OPALU),
        .NFCR(NFCR), .ZFCR(ZFCR), .OALUD(OALUD), .IFgn(IFgn), .IFgz(IFgz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model(input int op, input int a, input int b);
        case (op)
            0:  return a;
            1:  return (a + b) % 256;
            2:  return (a + 256 - b) % 256;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return 255 - a;
            7:  return (a * 2) % 256;
            8:  return a / 2;
            9:  return a / 2 + ((a >= 128) ? 128 : 0);
            10: return (a * 2) % 256 + a / 128;
            11: return a / 2 + (a % 2) * 128;
            12: return (a + 1) % 256;
            13: return (a + 255) % 256;
            14: return b;
            default: return -1;
        endcase
    endfunction

    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic nf, input logic zf);
        @(negedge clk);
        rst = r; Ira = a; Irb = b; OPALU = op; NFCR = nf; ZFCR = zf;
    endtask

    // Directed step: expectation given explicitly.
    task automatic dstep(input string tag, input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic nf, input logic zf,
                         input logic [7:0] ed, input logic en, input logic ez);
        exp_t e;
        apply(r, a, b, op, nf, zf);
        e.d = ed; e.n = en; e.z = ez; e.tag = tag;
        exp_q.push_back(e);
        m_d = ed; m_n = en; m_z = ez;
    endtask

    // Model step: expectation from the reference model.
    task automatic mstep(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic nf, input logic zf);
        exp_t e;
        int res;
        apply(r, a, b, op, nf, zf);
        res = model(int'(op), int'(a), int'(b));
        if (!r) begin
            m_d = 8'h00; m_n = 1'b0; m_z = 1'b0;
        end else if (res >= 0) begin
            m_d = res[7:0];
            if (nf) m_n = (res >= 128);
            if (zf) m_z = (res == 0);
        end
        e.d = m_d; e.n = m_n; e.z = m_z; e.tag = $sformatf("rnd_op%0h", op);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "_d"}, 32'(OALUD), 32'(e.d));
            chk({e.tag, "_n"}, 32'(IFgn), 32'(e.n));
            chk({e.tag, "_z"}, 32'(IFgz), 32'(e.z));
        end
    end

    initial begin
        rst = 1'b0; Ira = 8'h5A; Irb = 8'hA5; OPALU = 4'h1; NFCR = 1'b1; ZFCR = 1'b1;
        dstep("reset",   0, 8'h5A, 8'hA5, 4'h1, 1, 1, 8'h00, 0, 0);
        dstep("add2_2",  1, 8'h02, 8'h02, 4'h1, 1, 1, 8'h04, 0, 0);
        dstep("sub6_3",  1, 8'h06, 8'h03, 4'h2, 1, 1, 8'h03, 0, 0);
        dstep("sub3_6",  1, 8'h03, 8'h06, 4'h2, 1, 1, 8'hFD, 1, 0);
        dstep("and4_3",  1, 8'h04, 8'h03, 4'h3, 1, 1, 8'h00, 0, 1);
        dstep("zhold1",  1, 8'h05, 8'h05, 4'h2, 1, 0, 8'h00, 0, 1);
        dstep("zhold2",  1, 8'h01, 8'h00, 4'h1, 1, 0, 8'h01, 0, 1);
        dstep("ld80",    1, 8'h80, 8'h00, 4'h0, 1, 1, 8'h80, 1, 0);
        dstep("nop",     1, 8'h00, 8'h00, 4'hF, 1, 1, 8'h80, 1, 0);
        dstep("nhold",   1, 8'h00, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1);
        dstep("addwrap", 1, 8'hFF, 8'h01, 4'h1, 1, 1, 8'h00, 0, 1);
        dstep("midrst",  0, 8'h01, 8'h01, 4'h1, 1, 1, 8'h00, 0, 0);
        dstep("postrst", 1, 8'h10, 8'h00, 4'hC, 1, 1, 8'h11, 0, 0);
        dstep("decwrap", 1, 8'h00, 8'h00, 4'hD, 1, 1, 8'hFF, 1, 0);
        dstep("shl81",   1, 8'h81, 8'h00, 4'h7, 1, 1, 8'h02, 0, 0);
        dstep("shr81",   1, 8'h81, 8'h00, 4'h8, 1, 1, 8'h40, 0, 0);
        dstep("asr81",   1, 8'h81, 8'h00, 4'h9, 1, 1, 8'hC0, 1, 0);
        dstep("rol81",   1, 8'h81, 8'h00, 4'hA, 1, 1, 8'h03, 0, 0);
        dstep("ror81",   1, 8'h81, 8'h00, 4'hB, 1, 1, 8'hC0, 1, 0);
        dstep("not81",   1, 8'h81, 8'h00, 4'h6, 1, 1, 8'h7E, 0, 0);
        dstep("inc81",   1, 8'h81, 8'h00, 4'hC, 1, 1, 8'h82, 1, 0);
        dstep("dec81",   1, 8'h81, 8'h00, 4'hD, 1, 1, 8'h80, 1, 0);
        dstep("or",      1, 8'h0C, 8'h30, 4'h4, 1, 1, 8'h3C, 0, 0);
        dstep("xor",     1, 8'hF0, 8'hFF, 4'h5, 1, 1, 8'h0F, 0, 0);
        dstep("passb",   1, 8'h11, 8'hE7, 4'hE, 1, 1, 8'hE7, 1, 0);
        for (int i = 0; i < 300; i++) begin
            mstep(($urandom_range(0, 19) != 0), 8'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 16; i++) mstep(1, 8'h80, 8'h80, 4'(i), 1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
